vga_timing_gen: RTL and testbench

//  Parametrised VGA raster generator; replaces the separate ClockGen/Hsync/Vsync/RGB chain.

---
 rtl/vga_timing_gen.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster generator: pixel-enable divider, h/v counters,
//   sync/blank decode and RGB gating, with all pin-facing outputs sharing
//   one registered stage.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   en                    run enable; low freezes counters/divider, blanks outputs
//   x_req, y_req          live column/row counters (pixel source address)
//   r_in, g_in, b_in      pixel for (x_req, y_req), sampled in the same cycle
//   hsync, vsync, de      registered sync / display enable
//   r_out, g_out, b_out   registered colour, zero outside the visible region
//   line_start            1-clk pulse with the outputs at the first pixel of a line
//   frame_start           1-clk pulse with the outputs at pixel (0,0)
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 1,
    parameter int CW        = 4,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [HW-1:0] x_req,
    output logic [VW-1:0] y_req,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] r_out,
    output logic [CW-1:0] g_out,
    output logic [CW-1:0] b_out,
    output logic          line_start,
    output logic          frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Region boundaries kept 32 bits wide so a zero back porch cannot overflow
    // the counter width in the comparisons.
    localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
    localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
    localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = 1'(HSYNC_POL);
    localparam logic VS_ON = 1'(VSYNC_POL);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          ce;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    logic [31:0]   x_ext, y_ext;
    logic          h_act, v_act, h_sync, v_sync;

    // Divider and counters. ce fires on divider phase 0 so the very first
    // clk after reset (with en high) already advances from (0,0).
    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        ce    = en && (div_q == '0);
        if (en) begin
            div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        end
        if (ce) begin
            if (x_q == HW'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y_q == VW'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Region decode of the live counters.
    always_comb begin
        x_ext  = 32'(x_q);
        y_ext  = 32'(y_q);
        h_act  = x_ext < H_ACT_END;
        v_act  = y_ext < V_ACT_END;
        h_sync = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
        v_sync = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);
    end

    // Output stage: loads every clk; en low forces the idle/blank pattern.
    always_comb begin
        hsync_d = ~HS_ON;
        vsync_d = ~VS_ON;
        de_d    = 1'b0;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (en) begin
            de_d    = h_act && v_act;
            hsync_d = h_sync ? HS_ON : ~HS_ON;
            vsync_d = v_sync ? VS_ON : ~VS_ON;
            if (de_d) begin
                r_d = r_in;
                g_d = g_in;
                b_d = b_in;
            end
            ls_d = ce && (x_q == '0);
            fs_d = ce && (x_q == '0) && (y_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign x_req       = x_q;
    assign y_req       = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (CLK_DIV=1 and CLK_DIV=4) on a
// small 16x8 raster, driven by directed phases plus random en/reset, compared
// every clk against a pixel-index model of the raster.
module tb_vga_timing_gen;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] r_in = '0, g_in = '0, b_in = '0;

    logic [3:0] x1, x4;
    logic [2:0] y1, y4;
    logic       hs1, vs1, de1, ls1, fs1;
    logic       hs4, vs4, de4, ls4, fs4;
    logic [3:0] ro1, go1, bo1, ro4, go4, bo4;

    int n_tests = 0;
    int n_fail  = 0;
    int p  [2];   // model pixel index within the frame
    int ph [2];   // model divider phase
    int dv [2] = '{1, 4};
    bit ramp = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(1), .CW(4)
    ) dut1 (
        .clk(clk), .reset(reset), .en(en), .x_req(x1), .y_req(y1),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync(hs1), .vsync(vs1), .de(de1),
        .r_out(ro1), .g_out(go1), .b_out(bo1),
        .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(0), .VSYNC_POL(0), .CLK_DIV(4), .CW(4)
    ) dut4 (
        .clk(clk), .reset(reset), .en(en), .x_req(x4), .y_req(y4),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync(hs4), .vsync(vs4), .de(de4),
        .r_out(ro4), .g_out(go4), .b_out(bo4),
        .line_start(ls4), .frame_start(fs4)
    );

    // One clk: apply inputs, predict the registered outputs and the updated
    // live counters from the model, then check both instances after the edge.
    task automatic tick(input bit e, input bit r);
        logic [23:0] ex [2];
        logic [23:0] obs;
        logic [3:0]  ri, gi, bi;
        ri = ramp ? 4'(p[0] % HT) : 4'($urandom);
        gi = 4'($urandom);
        bi = 4'($urandom);
        en = e; reset = r; r_in = ri; g_in = gi; b_in = bi;
        for (int k = 0; k < 2; k++) begin
            int  x, y;
            bit  ce, d, hs, vs, ls, fs;
            logic [11:0] rgb;
            x  = p[k] % HT;
            y  = p[k] / HT;
            ce = (ph[k] == 0);
            if (r || !e) begin
                d = 0; hs = 1; vs = 1; ls = 0; fs = 0; rgb = '0;
            end else begin
                d   = (x < 8) && (y < 4);
                hs  = !(x >= 10 && x < 13);
                vs  = !(y >= 5 && y < 7);
                rgb = d ? {ri, gi, bi} : 12'h000;
                ls  = ce && (x == 0);
                fs  = ce && (p[k] == 0);
            end
            if (r) begin
                p[k] = 0; ph[k] = 0;
            end else if (e) begin
                if (ce) p[k] = (p[k] + 1) % FT;
                ph[k] = (ph[k] + 1) % dv[k];
            end
            ex[k] = {hs, vs, d, rgb, ls, fs, 4'(p[k] % HT), 3'(p[k] / HT)};
        end
        @(posedge clk);
        #1;
        obs = {hs1, vs1, de1, ro1, go1, bo1, ls1, fs1, x1, y1};
        n_tests++;
        assert (obs === ex[0]) else begin
            n_fail++;
            $error("FAIL div1 t=%0t obs=%h exp=%h", $time, obs, ex[0]);
        end
        obs = {hs4, vs4, de4, ro4, go4, bo4, ls4, fs4, x4, y4};
        n_tests++;
        assert (obs === ex[1]) else begin
            n_fail++;
            $error("FAIL div4 t=%0t obs=%h exp=%h", $time, obs, ex[1]);
        end
    endtask

    // Free-run the CLK_DIV=1 instance until its model reaches (x,y).
    task automatic run_to(input int x, input int y);
        for (int i = 0; i < 2 * FT && p[0] != y * HT + x; i++) tick(1, 0);
    endtask

    initial begin
        p  = '{0, 0};
        ph = '{0, 0};
        // Reset held 3 clks, then free run over two full frames.
        repeat (3) tick(1, 1);
        repeat (300) tick(1, 0);
        // Ramp on r_in follows the column address.
        ramp = 1'b1;
        repeat (40) tick(1, 0);
        ramp = 1'b0;
        // Mid-frame reset at (5,2).
        run_to(5, 2);
        tick(1, 1);
        repeat (30) tick(1, 0);
        // en low for 10 clks at (3,1), then resume.
        run_to(3, 1);
        repeat (10) tick(0, 0);
        repeat (60) tick(1, 0);
        // Random en / reset traffic, then a long clean run through a full
        // CLK_DIV=4 frame including the last-pixel wrap.
        repeat (400) tick(($urandom % 8) != 0, ($urandom % 64) == 0);
        repeat (600) tick(1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
